// File: rtl/trg_rx_pkg.sv
// rtl/trg_rx_pkg.sv - shared types and widths for the trigger-line receiver
package trg_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    LOW_MEAS,
    CHK_WAIT
  } trg_state_e;

  localparam int WIDTH_W = 8;
  localparam int GAP_W   = 5;
  localparam int ID_W    = 16;
  localparam int BUSY_W  = 20;

  function automatic logic in_range(input logic [WIDTH_W-1:0] w, input int lo, input int hi);
    return (int'(w) >= lo) && (int'(w) <= hi);
  endfunction

endpackage

// File: rtl/trg_in_sync.sv
// rtl/trg_in_sync.sv - 2-FF synchroniser plus edge register for the trigger line
// Resets to low so a line that is already low after reset looks like "not yet high".
module trg_in_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/trg_rx_decoder.sv
// rtl/trg_rx_decoder.sv - classifies low pulses on the trigger line, tracks trigger ID and busy
module trg_rx_decoder
  import trg_rx_pkg::*;
#(
  parameter int TRG_MIN   = 16,
  parameter int TRG_MAX   = 24,
  parameter int CHK_MIN   = 45,
  parameter int CHK_MAX   = 55,
  parameter int CHK_WIN   = 16,
  parameter int BUSY_MIN  = 500,
  parameter int CHK_PHASE = 0
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            trg_in_N,
  input  logic            rx_enb_in,
  input  logic            readout_done_in,
  output logic            trg_pulse_out,
  output logic [ID_W-1:0] trg_id_out,
  output logic            busy_out,
  output logic            chk_ok_out,
  output logic            chk_err_out,
  output logic            glitch_err_out,
  output logic            stuck_err_out,
  output logic            busy_viol_out
);

  localparam logic [BUSY_W-1:0]  BUSY_LOAD   = BUSY_W'(BUSY_MIN);
  localparam logic [GAP_W-1:0]   GAP_LIMIT   = GAP_W'(CHK_WIN);
  localparam logic [WIDTH_W-1:0] WIDTH_STUCK = WIDTH_W'(254);
  localparam logic [11:0]        PHASE       = 12'(CHK_PHASE);

  logic w_level, w_rise, w_fall;
  logic w_classify, w_is_trg, w_is_chk, w_accept;

  trg_rx_pkg::trg_state_e r_state;
  logic [WIDTH_W-1:0] r_width;
  logic [GAP_W-1:0]   r_gap;
  logic               r_after_trg;
  logic               r_meas_enb;
  logic [ID_W-1:0]    r_id;
  logic               r_trg_pulse, r_chk_ok, r_chk_err, r_glitch, r_stuck, r_busy_viol;
  logic               r_busy, r_done;
  logic [BUSY_W-1:0]  r_busy_tmr;

  trg_in_sync u_sync (
    .i_clk   (clk_in),
    .i_rst_n (rst_n_in),
    .i_line  (trg_in_N),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // A pulse counts only if decoding was enabled both when it started and when it ended.
  assign w_classify = (r_state == LOW_MEAS) && w_rise && r_meas_enb && rx_enb_in;
  assign w_is_trg   = in_range(r_width, TRG_MIN, TRG_MAX);
  assign w_is_chk   = in_range(r_width, CHK_MIN, CHK_MAX);
  assign w_accept   = w_classify && w_is_trg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= WAIT_HIGH;
      r_width     <= '0;
      r_gap       <= '0;
      r_after_trg <= 1'b0;
      r_meas_enb  <= 1'b0;
      r_id        <= '0;
      r_trg_pulse <= 1'b0;
      r_chk_ok    <= 1'b0;
      r_chk_err   <= 1'b0;
      r_glitch    <= 1'b0;
      r_stuck     <= 1'b0;
      r_busy_viol <= 1'b0;
    end else begin
      r_trg_pulse <= 1'b0;
      r_chk_ok    <= 1'b0;
      r_chk_err   <= 1'b0;
      r_glitch    <= 1'b0;
      r_busy_viol <= 1'b0;
      case (r_state)
        WAIT_HIGH: begin
          if (w_level) begin
            r_state <= IDLE;
            r_stuck <= 1'b0;
          end
        end
        IDLE: begin
          if (w_fall) begin
            r_state     <= LOW_MEAS;
            r_width     <= WIDTH_W'(1);
            r_after_trg <= 1'b0;
            r_meas_enb  <= rx_enb_in;
          end
        end
        LOW_MEAS: begin
          if (w_rise) begin
            r_state <= IDLE;
            if (w_accept) begin
              r_trg_pulse <= 1'b1;
              r_id        <= r_id + ID_W'(1);
              r_busy_viol <= r_busy;
              r_gap       <= GAP_W'(1);
              r_state     <= CHK_WAIT;
            end else if (w_classify && w_is_chk) begin
              if (r_after_trg && (r_id[11:0] == PHASE)) begin
                r_chk_ok <= 1'b1;
              end else begin
                r_chk_err <= 1'b1;
              end
            end else if (w_classify) begin
              r_glitch <= 1'b1;
            end
          end else begin
            r_width <= r_width + WIDTH_W'(1);
            if (r_width == WIDTH_STUCK) begin
              r_stuck <= 1'b1;
              r_state <= WAIT_HIGH;
            end
          end
        end
        CHK_WAIT: begin
          if (w_fall) begin
            r_state     <= LOW_MEAS;
            r_width     <= WIDTH_W'(1);
            r_after_trg <= 1'b1;
            r_meas_enb  <= rx_enb_in;
          end else if (r_gap == GAP_LIMIT) begin
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: r_state <= WAIT_HIGH;
      endcase
    end
  end

  // Busy holds at least BUSY_MIN cycles and until readout reports done; a new trigger restarts both.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy     <= 1'b0;
      r_busy_tmr <= '0;
      r_done     <= 1'b0;
    end else if (w_accept) begin
      r_busy     <= 1'b1;
      r_busy_tmr <= BUSY_LOAD;
      r_done     <= 1'b0;
    end else if (r_busy) begin
      if (r_busy_tmr != '0) r_busy_tmr <= r_busy_tmr - BUSY_W'(1);
      if (readout_done_in) r_done <= 1'b1;
      if ((r_busy_tmr == '0) && r_done) r_busy <= 1'b0;
    end
  end

  assign trg_pulse_out  = r_trg_pulse;
  assign trg_id_out     = r_id;
  assign busy_out       = r_busy;
  assign chk_ok_out     = r_chk_ok;
  assign chk_err_out    = r_chk_err;
  assign glitch_err_out = r_glitch;
  assign stuck_err_out  = r_stuck;
  assign busy_viol_out  = r_busy_viol;

endmodule

// File: tb/tb_trg_rx_decoder.sv
// tb/tb_trg_rx_decoder.sv - directed self-checking bench for trg_rx_decoder
module tb_trg_rx_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trg_n = 1'b1;
  logic        rx_enb = 1'b1;
  logic        rdone = 1'b0;
  logic        trg_pulse, busy, chk_ok, chk_err, glitch, stuck, viol;
  logic [15:0] trg_id;

  int checks = 0;
  int errors = 0;
  int n_trg = 0, n_ok = 0, n_err = 0, n_gl = 0, n_viol = 0;

  trg_rx_decoder dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .trg_in_N        (trg_n),
    .rx_enb_in       (rx_enb),
    .readout_done_in (rdone),
    .trg_pulse_out   (trg_pulse),
    .trg_id_out      (trg_id),
    .busy_out        (busy),
    .chk_ok_out      (chk_ok),
    .chk_err_out     (chk_err),
    .glitch_err_out  (glitch),
    .stuck_err_out   (stuck),
    .busy_viol_out   (viol)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    #1;
    n_trg  = n_trg + int'(trg_pulse);
    n_ok   = n_ok + int'(chk_ok);
    n_err  = n_err + int'(chk_err);
    n_gl   = n_gl + int'(glitch);
    n_viol = n_viol + int'(viol);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic low_pulse(input int n);
    @(negedge clk);
    trg_n = 1'b0;
    repeat (n) @(negedge clk);
    trg_n = 1'b1;
  endtask

  task automatic trg_chk(input int gap);
    low_pulse(20);
    wait_clk(gap - 1);
    low_pulse(50);
  endtask

  task automatic readout_pulse();
    @(negedge clk);
    rdone = 1'b1;
    @(negedge clk);
    rdone = 1'b0;
  endtask

  task automatic test_reset();
    wait_clk(4);
    checks++;
    if ({trg_pulse, chk_ok, chk_err, glitch, stuck, viol, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0000000", {trg_pulse, chk_ok, chk_err, glitch, stuck, viol, busy});
    end
    checks++;
    if (trg_id !== 16'h0000) begin
      errors++;
      $display("FAIL reset_id: got %h want 0000", trg_id);
    end
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_trigger();
    logic [3:0] seen;
    seen = '0;
    low_pulse(20);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen[i] = trg_pulse;
    end
    checks++;
    if (seen !== 4'b0100) begin
      errors++;
      $display("FAIL trg_latency: got %b want 0100", seen);
    end
    checks++;
    if (trg_id !== 16'd1) begin
      errors++;
      $display("FAIL trg_id_first: got %0d want 1", trg_id);
    end
    wait_clk(498);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_min_hold: got %b want 1", busy);
    end
    wait_clk(101);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_wait_done: got %b want 1", busy);
    end
    readout_pulse();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_done_lat1: got %b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_release: got %b want 0", busy);
    end
  endtask

  task automatic test_busy_viol();
    low_pulse(20);
    wait_clk(3);
    checks++;
    if ({trg_pulse, viol} !== 2'b10) begin
      errors++;
      $display("FAIL viol_idle_trigger: got %b want 10", {trg_pulse, viol});
    end
    wait_clk(77);
    low_pulse(20);
    wait_clk(3);
    checks++;
    if ({trg_pulse, viol, busy} !== 3'b111) begin
      errors++;
      $display("FAIL viol_strobe: got %b want 111", {trg_pulse, viol, busy});
    end
    checks++;
    if (trg_id !== 16'd3) begin
      errors++;
      $display("FAIL viol_id: got %0d want 3", trg_id);
    end
    wait_clk(199);
    readout_pulse();
    wait_clk(294);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL viol_hold_restart: got %b want 1", busy);
    end
    wait_clk(10);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL viol_release: got %b want 0", busy);
    end
  endtask

  task automatic test_check_err();
    int ok0, err0;
    low_pulse(20);
    wait_clk(40);
    ok0 = n_ok;
    err0 = n_err;
    trg_chk(10);
    wait_clk(5);
    checks++;
    if ((n_err - err0 !== 1) || (n_ok - ok0 !== 0)) begin
      errors++;
      $display("FAIL chk_mismatch: got err=%0d ok=%0d want err=1 ok=0", n_err - err0, n_ok - ok0);
    end
    checks++;
    if (trg_id !== 16'd5) begin
      errors++;
      $display("FAIL chk_id: got %0d want 5", trg_id);
    end
    wait_clk(40);
    err0 = n_err;
    low_pulse(50);
    wait_clk(5);
    checks++;
    if ((n_err - err0 !== 1) || (trg_id !== 16'd5)) begin
      errors++;
      $display("FAIL chk_orphan: got err=%0d id=%0d want err=1 id=5", n_err - err0, trg_id);
    end
  endtask

  task automatic test_glitch();
    int widths[7] = '{3, 30, 60, 15, 25, 44, 56};
    int gl0, trg0;
    gl0 = n_gl;
    trg0 = n_trg;
    foreach (widths[i]) begin
      low_pulse(widths[i]);
      wait_clk(20);
    end
    checks++;
    if ((n_gl - gl0 !== 7) || (n_trg - trg0 !== 0) || (trg_id !== 16'd5)) begin
      errors++;
      $display("FAIL glitch_count: got gl=%0d trg=%0d id=%0d want 7 0 5", n_gl - gl0, n_trg - trg0, trg_id);
    end
    low_pulse(16);
    wait_clk(40);
    low_pulse(24);
    wait_clk(40);
    checks++;
    if ((n_trg - trg0 !== 2) || (trg_id !== 16'd7) || (n_gl - gl0 !== 7)) begin
      errors++;
      $display("FAIL trg_bounds: got trg=%0d id=%0d gl=%0d want 2 7 7", n_trg - trg0, trg_id, n_gl - gl0);
    end
    rx_enb = 1'b0;
    low_pulse(20);
    wait_clk(20);
    low_pulse(3);
    wait_clk(20);
    rx_enb = 1'b1;
    checks++;
    if ((n_trg - trg0 !== 2) || (n_gl - gl0 !== 7) || (trg_id !== 16'd7)) begin
      errors++;
      $display("FAIL rx_disabled: got trg=%0d gl=%0d id=%0d want 2 7 7", n_trg - trg0, n_gl - gl0, trg_id);
    end
  endtask

  task automatic test_stuck();
    int gl0;
    gl0 = n_gl;
    @(negedge clk);
    trg_n = 1'b0;
    wait_clk(250);
    checks++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL stuck_early: got %b want 0", stuck);
    end
    wait_clk(20);
    checks++;
    if (stuck !== 1'b1) begin
      errors++;
      $display("FAIL stuck_set: got %b want 1", stuck);
    end
    wait_clk(30);
    trg_n = 1'b1;
    checks++;
    if (stuck !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold: got %b want 1", stuck);
    end
    wait_clk(5);
    checks++;
    if ((stuck !== 1'b0) || (n_gl - gl0 !== 0)) begin
      errors++;
      $display("FAIL stuck_clear: got stuck=%b gl=%0d want 0 0", stuck, n_gl - gl0);
    end
  endtask

  task automatic test_reset_mid();
    int trg0;
    @(negedge clk);
    trg_n = 1'b0;
    wait_clk(10);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({trg_pulse, chk_ok, chk_err, glitch, stuck, viol, busy, trg_id} !== 23'b0) begin
      errors++;
      $display("FAIL reset_mid: got %b id=%h want all 0", {trg_pulse, chk_ok, chk_err, glitch, stuck, viol, busy}, trg_id);
    end
    wait_clk(2);
    rst_n = 1'b1;
    trg0 = n_trg;
    wait_clk(20);
    trg_n = 1'b1;
    wait_clk(10);
    checks++;
    if ((n_trg - trg0 !== 0) || (trg_id !== 16'd0)) begin
      errors++;
      $display("FAIL reset_tail_ignored: got trg=%0d id=%0d want 0 0", n_trg - trg0, trg_id);
    end
    low_pulse(20);
    wait_clk(3);
    checks++;
    if ((trg_pulse !== 1'b1) || (trg_id !== 16'd1)) begin
      errors++;
      $display("FAIL reset_resume: got pulse=%b id=%0d want 1 1", trg_pulse, trg_id);
    end
  endtask

  task automatic test_rollover();
    int trg0, err0;
    logic [3:0] seen;
    seen = '0;
    wait_clk(40);
    rst_n = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(5);
    trg0 = n_trg;
    for (int i = 0; i < 4095; i++) begin
      @(negedge clk);
      trg_n = 1'b0;
      wait_clk(16);
      trg_n = 1'b1;
    end
    wait_clk(10);
    checks++;
    if ((trg_id !== 16'h0FFF) || (n_trg - trg0 !== 4095)) begin
      errors++;
      $display("FAIL roll_count: got id=%h trg=%0d want 0fff 4095", trg_id, n_trg - trg0);
    end
    err0 = n_err;
    trg_chk(10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen[i] = chk_ok;
    end
    checks++;
    if (seen !== 4'b0100) begin
      errors++;
      $display("FAIL chk_ok_strobe: got %b want 0100", seen);
    end
    checks++;
    if ((trg_id !== 16'h1000) || (n_err - err0 !== 0)) begin
      errors++;
      $display("FAIL chk_ok_id: got id=%h err=%0d want 1000 0", trg_id, n_err - err0);
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_busy_viol();
    test_check_err();
    test_glitch();
    test_stuck();
    test_reset_mid();
    test_rollover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
